// File: rtl/router_output_arbiter.sv
// Round-robin arbiter and read sequencer sharing one router output port between NUM_IN input FIFOs.
// Optional build macro ROUTER_ARB_PRIO_EN: port 0 wins every arbitration cycle in which it is non-empty.
module router_output_arbiter #(
   parameter int NUM_IN   = 4,
   parameter int WIRE_NUM = 29,
   parameter int BURST    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN-1:0]            in_empty,
   input  logic [NUM_IN*WIRE_NUM-1:0]   in_data,
   input  logic                         out_full,
   output logic [NUM_IN-1:0]            in_read,
   output logic                         out_write,
   output logic [WIRE_NUM-1:0]          out_data,
   output logic                         grant_valid,
   output logic [$clog2(NUM_IN)-1:0]    grant_id
);
   localparam int GW = $clog2(NUM_IN);
   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grant_id_q, grant_id_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic [GW-1:0] winner;
   logic          found;
   logic          xfer;
   logic          last_flit;
   logic [WIRE_NUM-1:0] sel_data;

   // Search starts just after the last winner so every port gets a turn.
   always_comb begin : arbitrate
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_IN;
         if (!found && !in_empty[GW'(idx)]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
`ifdef ROUTER_ARB_PRIO_EN
      if (!in_empty[0]) begin
         winner = '0;
         found  = 1'b1;
      end
`endif
   end

   always_comb begin : data_mux
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (GW'(i) == grant_id_q) sel_data = in_data[i*WIRE_NUM +: WIRE_NUM];
      end
   end

   assign xfer      = (state_q == BUSY) && !in_empty[grant_id_q] && !out_full;
   assign last_flit = (burst_cnt_q == CW'(BURST - 1));

   always_comb begin : next_state
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = BUSY;
               grant_id_d  = winner;
               rr_ptr_d    = winner;
               burst_cnt_d = '0;
            end
         end
         BUSY: begin
            // A drained FIFO releases the grant; a full downstream just stalls.
            if (in_empty[grant_id_q]) begin
               state_d = IDLE;
            end else if (!out_full) begin
               if (last_flit) state_d = IDLE;
               else           burst_cnt_d = burst_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= GW'(NUM_IN - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin : strobes
      in_read = '0;
      if (xfer) in_read[grant_id_q] = 1'b1;
   end

   assign out_write   = xfer;
   assign out_data    = xfer ? sel_data : '0;
   assign grant_valid = (state_q == BUSY);
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: queue-based FIFO models, a behavioural arbiter model and directed scenarios.
module tb_router_output_arbiter;
   localparam int NUM_IN   = 4;
   localparam int WIRE_NUM = 29;
   localparam int BURST    = 4;
   localparam int GW       = $clog2(NUM_IN);

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [NUM_IN-1:0]          in_empty;
   logic [NUM_IN*WIRE_NUM-1:0] in_data;
   logic                       out_full = 1'b0;
   logic [NUM_IN-1:0]          in_read;
   logic                       out_write;
   logic [WIRE_NUM-1:0]        out_data;
   logic                       grant_valid;
   logic [GW-1:0]              grant_id;

   router_output_arbiter #(.NUM_IN(NUM_IN), .WIRE_NUM(WIRE_NUM), .BURST(BURST)) dut (
      .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_data(in_data), .out_full(out_full),
      .in_read(in_read), .out_write(out_write), .out_data(out_data),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_writes = 0;

   logic [WIRE_NUM-1:0] fifo_q [NUM_IN][$];
   logic [WIRE_NUM-1:0] exp_q[$];
   int                  glog[$];
   logic                gv_prev = 1'b0;

   // behavioural model: busy flag, granted port, flits moved this grant, last winner
   bit m_busy;
   int m_gid;
   int m_sent;
   int m_last;

   typedef struct {
      logic [NUM_IN-1:0] nonempty;
      int                exp_first;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NUM_IN; i++) begin
         in_empty[i] = (fifo_q[i].size() == 0);
         in_data[i*WIRE_NUM +: WIRE_NUM] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : WIRE_NUM'($urandom);
      end
   endtask

   task automatic push_flits(input int port, input int n);
      for (int i = 0; i < n; i++) fifo_q[port].push_back(WIRE_NUM'($urandom));
      drive_inputs();
   endtask

   task automatic do_reset(input bit clear);
      rst_n  = 1'b0;
      m_busy = 1'b0;
      m_gid  = 0;
      m_sent = 0;
      m_last = NUM_IN - 1;
      if (clear) for (int i = 0; i < NUM_IN; i++) fifo_q[i].delete();
      exp_q.delete();
      glog.delete();
      gv_prev  = 1'b0;
      n_writes = 0;
      out_full = 1'b0;
      drive_inputs();
      @(negedge clk);
      check("rst_in_read", in_read, 0);
      check("rst_out_write", out_write, 0);
      check("rst_grant_valid", grant_valid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock: compare outputs at the falling edge, advance model, pop FIFOs after the rising edge.
   task automatic tick();
      logic [NUM_IN-1:0]   e_read;
      logic                e_write;
      logic [WIRE_NUM-1:0] e_data;
      int                  win;
      int                  pop_port;
      e_read = '0; e_write = 1'b0; e_data = '0; pop_port = -1;
      @(negedge clk);
      if (m_busy && fifo_q[m_gid].size() > 0 && !out_full) begin
         e_read[m_gid] = 1'b1;
         e_write       = 1'b1;
         e_data        = fifo_q[m_gid][0];
         pop_port      = m_gid;
         exp_q.push_back(e_data);
      end
      check("in_read", in_read, e_read);
      check("out_write", out_write, e_write);
      check("grant_valid", grant_valid, m_busy);
      check("grant_id", grant_id, m_gid);
      if (!e_write) check("out_data_idle", out_data, 0);
      if (out_write) begin
         n_writes++;
         if (exp_q.size() == 0) check("scoreboard_extra_write", 1, 0);
         else check("out_data", out_data, exp_q.pop_front());
      end
      if (grant_valid && !gv_prev) glog.push_back(int'(grant_id));
      gv_prev = grant_valid;
      if (!m_busy) begin
         win = -1;
`ifdef ROUTER_ARB_PRIO_EN
         if (fifo_q[0].size() > 0) win = 0;
`endif
         for (int k = 1; k <= NUM_IN && win < 0; k++)
            if (fifo_q[(m_last + k) % NUM_IN].size() > 0) win = (m_last + k) % NUM_IN;
         if (win >= 0) begin
            m_busy = 1'b1; m_gid = win; m_last = win; m_sent = 0;
         end
      end else if (e_write) begin
         m_sent++;
         if (m_sent == BURST) m_busy = 1'b0;
      end else if (fifo_q[m_gid].size() == 0) begin
         m_busy = 1'b0;
      end
      @(posedge clk);
      #1;
      if (pop_port >= 0) void'(fifo_q[pop_port].pop_front());
      drive_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_until_idle(input string name, input int budget);
      bit done;
      int total;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         total = 0;
         for (int p = 0; p < NUM_IN; p++) total += fifo_q[p].size();
         if (total == 0 && !m_busy && !grant_valid) done = 1'b1;
         else tick();
      end
      check(name, done, 1);
   endtask

   task automatic run_until_grants(input string name, input int n, input int budget);
      for (int i = 0; i < budget && glog.size() < n; i++) tick();
      check(name, glog.size() >= n, 1);
   endtask

   int exp_order[8];
   int exp_alt[4];

   initial begin
      vecs[0] = '{4'b0100, 2};
      vecs[1] = '{4'b1001, 0};
      vecs[2] = '{4'b0110, 1};
      vecs[3] = '{4'b1000, 3};
      vecs[4] = '{4'b1111, 0};
      vecs[5] = '{4'b1010, 1};

      do_reset(1'b1);
      check("rst_grant_id", grant_id, 0);

      // single FIFO with three flits, then one drained BUSY cycle
      do_reset(1'b1);
      push_flits(2, 3);
      run(6);
      check("s1_writes", n_writes, 3);
      check("s1_grants", glog.size(), 1);
      if (glog.size() >= 1) check("s1_grant", glog[0], 2);
      check("s1_idle_end", grant_valid, 0);

      // first winner after reset for a table of occupancy patterns
      foreach (vecs[v]) begin
         do_reset(1'b1);
         for (int p = 0; p < NUM_IN; p++) if (vecs[v].nonempty[p]) push_flits(p, 2);
         run_until_grants($sformatf("tbl%0d_grant_timeout", v), 1, 5);
         if (glog.size() >= 1) check($sformatf("tbl%0d_first", v), glog[0], vecs[v].exp_first);
         run_until_idle($sformatf("tbl%0d_drain", v), 60);
      end

      // fairness: four FIFOs with eight flits each
`ifdef ROUTER_ARB_PRIO_EN
      exp_order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      do_reset(1'b1);
      for (int p = 0; p < NUM_IN; p++) push_flits(p, 8);
      run_until_idle("fair_drain", 100);
      check("fair_writes", n_writes, 32);
      check("fair_grants", glog.size(), 8);
      if (glog.size() == 8) foreach (exp_order[i]) check($sformatf("fair_order%0d", i), glog[i], exp_order[i]);

      // downstream stall after the second flit of a grant on FIFO 1
      do_reset(1'b1);
      push_flits(1, 6);
      run(3);
      out_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_read", in_read, 0);
         check("stall_write", out_write, 0);
         check("stall_gv", grant_valid, 1);
         check("stall_gid", grant_id, 1);
      end
      out_full = 1'b0;
      run_until_idle("stall_drain", 40);
      check("stall_writes", n_writes, 6);
      check("stall_grants", glog.size(), 2);

      // asynchronous reset during the third flit of a burst
      do_reset(1'b1);
      push_flits(2, 8);
      push_flits(3, 8);
      run(3);
      #2;
      check("mid_pre_read", in_read, 4'b0100);
      rst_n = 1'b0;
      #1;
      check("mid_read", in_read, 0);
      check("mid_write", out_write, 0);
      check("mid_gv", grant_valid, 0);
      check("mid_data", out_data, 0);
      do_reset(1'b0);
      run_until_grants("mid_regrant_timeout", 1, 5);
      if (glog.size() >= 1) check("mid_first_grant", glog[0], 2);
      run_until_idle("mid_drain", 100);

      // wrap-around from rr_ptr=3 with FIFOs 0 and 3 occupied
      do_reset(1'b1);
      push_flits(0, 2);
      push_flits(3, 2);
      run_until_idle("wrap_drain", 30);
      check("wrap_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         check("wrap_g0", glog[0], 0);
         check("wrap_g1", glog[1], 3);
      end

      // FIFOs 0 and 2 continuously occupied
`ifdef ROUTER_ARB_PRIO_EN
      exp_alt = '{0, 0, 0, 0};
`else
      exp_alt = '{0, 2, 0, 2};
`endif
      do_reset(1'b1);
      push_flits(0, 20);
      push_flits(2, 20);
      run_until_grants("alt_timeout", 4, 60);
      if (glog.size() >= 4) foreach (exp_alt[i]) check($sformatf("alt%0d", i), glog[i], exp_alt[i]);
      run_until_idle("alt_drain", 100);

      // randomized traffic with random downstream backpressure
      do_reset(1'b1);
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int p;
            p = $urandom_range(0, NUM_IN - 1);
            if (fifo_q[p].size() < 12) push_flits(p, $urandom_range(1, 5));
         end
         out_full = ($urandom_range(0, 3) == 0);
         tick();
      end
      out_full = 1'b0;
      run_until_idle("rand_drain", 300);
      check("rand_scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
